sha_stream_ctrl: RTL

- Sequences the SHA3-512 wrapper (`sha`) for the UART hashing path.
- Takes a byte stream from the UART receiver, parses a one-byte word-count header and packs the payload bytes big-endian into 32-bit words.
- Feeds those words to `sha` with a valid/ready handshake, issues the last marker, waits for the hash, then serialises the 64 hash bytes to the UART transmitter.
- Resets `sha` between messages and reports timeout and overrun errors.

---
 rtl/sha_stream_ctrl.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/sha_stream_ctrl.sv
// sha_stream_ctrl: sequences the SHA3-512 wrapper for the UART hashing path.
// Parses a word-count header, packs payload bytes big-endian into words,
// feeds them to sha, waits for the hash and streams 64 hash bytes to TX.
module sha_stream_ctrl #(
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int RST_CYCLES     = 2
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [7:0]   rx_data_i,
  input  logic         rx_valid_i,
  output logic [7:0]   tx_data_o,
  output logic         tx_valid_o,
  input  logic         tx_ready_i,
  output logic         sha_rst_o,
  output logic [31:0]  sha_data_o,
  output logic         sha_valid_o,
  output logic         sha_last_o,
  input  logic         sha_ready_i,
  input  logic [511:0] sha_hash_i,
  input  logic         sha_valid_i,
  output logic         busy_o,
  output logic         err_timeout_o,
  output logic         err_overrun_o
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int RW = $clog2(RST_CYCLES + 1);

  typedef enum logic [2:0] {
    S_CLR, S_HDR, S_COLLECT, S_PUSH, S_LAST, S_WAIT, S_SEND
  } state_t;

  state_t         state, state_nxt;
  logic [RW-1:0]  rst_cnt;
  logic [TW-1:0]  tmo_cnt;
  logic [7:0]     words_left;
  logic [1:0]     byte_cnt;
  logic [31:0]    word;
  logic           skid_valid;
  logic [7:0]     skid_data;
  logic [511:0]   shreg;
  logic [5:0]     tx_cnt;
  logic           err_timeout;
  logic           err_overrun;
  logic           col_take;
  logic [7:0]     col_byte;

  // The skid byte, when present, is always older than any byte on rx.
  assign col_take = (state == S_COLLECT) && (skid_valid || rx_valid_i);
  assign col_byte = skid_valid ? skid_data : rx_data_i;

  assign err_timeout_o = err_timeout;
  assign err_overrun_o = err_overrun;

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) state <= S_CLR;
    else       state <= state_nxt;
  end

  // Next-state decode and Moore outputs derived from the current state.
  always_comb begin
    state_nxt   = state;
    sha_rst_o   = 1'b0;
    sha_data_o  = 32'h0;
    sha_valid_o = 1'b0;
    sha_last_o  = 1'b0;
    tx_data_o   = 8'h00;
    tx_valid_o  = 1'b0;
    busy_o      = 1'b1;
    case (state)
      S_CLR: begin
        sha_rst_o = 1'b1;
        if (rst_cnt == RW'(RST_CYCLES - 1)) state_nxt = S_HDR;
      end
      S_HDR: begin
        busy_o = 1'b0;
        if (rx_valid_i) state_nxt = (rx_data_i == 8'h00) ? S_LAST : S_COLLECT;
      end
      S_COLLECT: begin
        if (col_take && byte_cnt == 2'd3) state_nxt = S_PUSH;
      end
      S_PUSH: begin
        sha_valid_o = 1'b1;
        sha_data_o  = word;
        if (sha_ready_i) state_nxt = (words_left == 8'd1) ? S_LAST : S_COLLECT;
      end
      S_LAST: begin
        sha_last_o = 1'b1;
        if (sha_ready_i) state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (sha_valid_i) state_nxt = S_SEND;
        else if (tmo_cnt == TW'(TIMEOUT_CYCLES - 1)) state_nxt = S_CLR;
      end
      S_SEND: begin
        tx_valid_o = 1'b1;
        tx_data_o  = shreg[511:504];
        if (tx_ready_i && tx_cnt == 6'd63) state_nxt = S_CLR;
      end
      default: state_nxt = S_CLR;
    endcase
  end

  // Datapath: header/word packing, skid buffer, timeout, hash shifter, errors.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rst_cnt     <= '0;
      tmo_cnt     <= '0;
      words_left  <= 8'h00;
      byte_cnt    <= 2'd0;
      word        <= 32'h0;
      skid_valid  <= 1'b0;
      skid_data   <= 8'h00;
      shreg       <= '0;
      tx_cnt      <= 6'd0;
      err_timeout <= 1'b0;
      err_overrun <= 1'b0;
    end else begin
      rst_cnt <= (state == S_CLR) ? rst_cnt + 1'b1 : '0;
      case (state)
        S_HDR: begin
          if (rx_valid_i) begin
            words_left <= rx_data_i;
            byte_cnt   <= 2'd0;
            skid_valid <= 1'b0;
          end
        end
        S_COLLECT: begin
          if (col_take) begin
            word     <= {word[23:0], col_byte};
            byte_cnt <= byte_cnt + 1'b1;
            if (skid_valid) begin
              skid_valid <= rx_valid_i;
              skid_data  <= rx_data_i;
            end
          end
        end
        S_PUSH: begin
          if (rx_valid_i) begin
            if (!skid_valid) begin
              skid_valid <= 1'b1;
              skid_data  <= rx_data_i;
            end else begin
              err_overrun <= 1'b1;
            end
          end
          if (sha_ready_i) begin
            words_left <= words_left - 1'b1;
            byte_cnt   <= 2'd0;
            if (words_left == 8'd1) skid_valid <= 1'b0;
          end
        end
        S_LAST: begin
          if (rx_valid_i) err_overrun <= 1'b1;
          if (sha_ready_i) tmo_cnt <= '0;
        end
        S_WAIT: begin
          if (rx_valid_i) err_overrun <= 1'b1;
          if (sha_valid_i) begin
            shreg   <= sha_hash_i;
            tmo_cnt <= '0;
            tx_cnt  <= 6'd0;
          end else if (tmo_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
            err_timeout <= 1'b1;
            tmo_cnt     <= '0;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        S_SEND: begin
          if (rx_valid_i) err_overrun <= 1'b1;
          if (tx_ready_i) begin
            shreg  <= {shreg[503:0], 8'h00};
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
        default: begin
          if (rx_valid_i) err_overrun <= 1'b1;
        end
      endcase
    end
  end

endmodule
